// File: rtl/mul_op_master.sv
// ----------------------------------------------------------------------------
// mul_op_master
//
// Initiator side of the multiplier control handshake. It accepts one operand
// pair over a valid/ready request port, strobes op_start, and then waits for
// op_done. The wait is bounded by a timeout and can be cut short by a
// software abort. Whatever the outcome, it pulses op_clear so that the
// multiplier returns to its start state. It then presents the product, an
// error code and the number of WAIT cycles on a valid/ready response port.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_a, req_b operands
//   abort                   software abort, only honoured in WAIT
//   rsp_valid/rsp_ready     response handshake
//   rsp_result              captured product (0 on error)
//   rsp_err                 00 ok, 01 timeout, 10 abort
//   rsp_cycles              WAIT cycles counted until the operation exited
//   op_start/op_clear       one-cycle strobes to the multiplier
//   mul_a/mul_b             operands, held from START until the response
//                           handshake completes
//   op_done/mul_result      multiplier completion and product
//   busy                    high in every state except IDLE
// ----------------------------------------------------------------------------
module mul_op_master #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    input  logic                 abort,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic [1:0]           rsp_err,
    output logic [CNT_W-1:0]     rsp_cycles,
    output logic                 op_start,
    output logic                 op_clear,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 op_done,
    input  logic [2*WIDTH-1:0]   mul_result,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        CLEAR = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [1:0]       ERR_OK      = 2'b00;
    localparam logic [1:0]       ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]       ERR_ABORT   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [WIDTH-1:0]     mul_a_reg, mul_b_reg;
    logic [2*WIDTH-1:0]   result_reg;
    logic [1:0]           err_reg;
    logic [CNT_W-1:0]     cycles_reg;

    logic                 wait_exit;
    logic [1:0]           exit_err;

    // Next-state and WAIT exit decode. Priority in WAIT: abort, then
    // op_done, then timeout. So an op_done that lands on the last allowed
    // cycle still counts as a success.
    always_comb begin
        state_next = state_reg;
        wait_exit  = 1'b0;
        exit_err   = ERR_OK;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (abort) begin
                    wait_exit = 1'b1;
                    exit_err  = ERR_ABORT;
                end else if (op_done) begin
                    wait_exit = 1'b1;
                    exit_err  = ERR_OK;
                end else if (cnt_reg == CNT_LAST) begin
                    wait_exit = 1'b1;
                    exit_err  = ERR_TIMEOUT;
                end
                if (wait_exit) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The state register and the datapath are reset together. A reset in
    // the middle of an operation simply drops it. No op_clear is sent,
    // because the multiplier is reset by the same reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            mul_a_reg  <= '0;
            mul_b_reg  <= '0;
            result_reg <= '0;
            err_reg    <= ERR_OK;
            cycles_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        mul_a_reg <= req_a;
                        mul_b_reg <= req_b;
                    end
                end
                START: begin
                    cnt_reg <= '0;
                end
                WAIT: begin
                    if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                    if (wait_exit) begin
                        err_reg    <= exit_err;
                        result_reg <= (exit_err == ERR_OK) ? mul_result : '0;
                        // The exit cycle itself counts as a WAIT cycle.
                        // cnt_reg never exceeds TIMEOUT-1 here, so this
                        // cannot wrap.
                        cycles_reg <= cnt_reg + CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        mul_a_reg <= '0;
                        mul_b_reg <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and strobe outputs come straight from the state register,
    // so they are glitch-free and mutually exclusive.
    assign req_ready  = (state_reg == IDLE);
    assign op_start   = (state_reg == START);
    assign op_clear   = (state_reg == CLEAR);
    assign rsp_valid  = (state_reg == RESP);
    assign busy       = (state_reg != IDLE);
    assign mul_a      = mul_a_reg;
    assign mul_b      = mul_b_reg;
    assign rsp_result = result_reg;
    assign rsp_err    = err_reg;
    assign rsp_cycles = cycles_reg;

endmodule

// File: tb/tb_mul_op_master.sv
module tb_mul_op_master;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        abort;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [1:0]  rsp_err;
    logic [5:0]  rsp_cycles;
    logic        op_start;
    logic        op_clear;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        op_done;
    logic [63:0] mul_result;
    logic        busy;

    int checks;
    int errors;

    mul_op_master #(.WIDTH(32), .TIMEOUT(40), .CNT_W(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .abort      (abort),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_cycles (rsp_cycles),
        .op_start   (op_start),
        .op_clear   (op_clear),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .op_done    (op_done),
        .mul_result (mul_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;       // value the multiplier model presents with op_done
        int          done_at;    // WAIT cycle (1-based) with op_done high, 0 = never
        int          abort_at;   // WAIT cycle with abort high, 0 = never
        int          hold;       // cycles rsp_ready is held low in RESP
        logic [63:0] exp_result;
        logic [1:0]  exp_err;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  req_ready,  1);
        chk({tag, "_op_start"},   op_start,   0);
        chk({tag, "_op_clear"},   op_clear,   0);
        chk({tag, "_rsp_valid"},  rsp_valid,  0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_mul_a"},      mul_a,      0);
        chk({tag, "_mul_b"},      mul_b,      0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_err"},    rsp_err,    0);
        chk({tag, "_rsp_cycles"}, rsp_cycles, 0);
    endtask

    // Runs one operation. It is entered and left on a falling edge with the
    // DUT in IDLE. The multiplier model counts WAIT cycles itself.
    task automatic run_op(input int idx, input vec_t v);
        int k;
        int starts;
        bit exited;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_a     = v.a;
        req_b     = v.b;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        chk("start_op_start",  op_start,  1);
        chk("start_req_ready", req_ready, 0);
        chk("start_busy",      busy,      1);
        chk("start_op_clear",  op_clear,  0);
        chk("start_mul_a",     mul_a,     {32'd0, v.a});
        chk("start_mul_b",     mul_b,     {32'd0, v.b});
        // An abort raised during START is held into the first WAIT cycle.
        if (v.abort_at == 1) abort = 1'b1;
        k      = 0;
        starts = 0;
        exited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (op_clear) begin
                exited = 1;
                break;
            end
            if (op_start) starts++;
            k++;
            op_done    = (k == v.done_at);
            abort      = (k == v.abort_at);
            mul_result = (k == v.done_at) ? v.prod : 64'hDEAD_BEEF_0BAD_F00D;
        end
        op_done = 1'b0;
        abort   = 1'b0;
        chk("wait_exit_seen",   exited,   1);
        chk("wait_cycles",      k,        v.exp_cycles);
        chk("extra_op_start",   starts,   0);
        chk("clear_op_start",   op_start, 0);
        chk("clear_rsp_valid",  rsp_valid, 0);
        chk("clear_mul_a_held", mul_a,    {32'd0, v.a});
        @(negedge clk);
        chk("resp_rsp_valid",  rsp_valid,  1);
        chk("resp_op_clear",   op_clear,   0);
        chk("resp_req_ready",  req_ready,  0);
        chk("resp_result",     rsp_result, v.exp_result);
        chk("resp_err",        rsp_err,    v.exp_err);
        chk("resp_cycles",     rsp_cycles, v.exp_cycles);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid,  1);
            chk("hold_result",    rsp_result, v.exp_result);
            chk("hold_err",       rsp_err,    v.exp_err);
            chk("hold_cycles",    rsp_cycles, v.exp_cycles);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_busy",      busy,      0);
        chk("post_mul_a",     mul_a,     0);
        chk("post_mul_b",     mul_b,     0);
        chk("post_op_clear",  op_clear,  0);
        $display("txn %0d: a=%08h b=%08h result=%016h err=%02b cycles=%0d wait=%0d",
                 idx, v.a, v.b, v.exp_result, v.exp_err, v.exp_cycles, k);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        abort      = 1'b0;
        rsp_ready  = 1'b0;
        op_done    = 1'b0;
        mul_result = '0;

        vecs[0] = '{32'd3, 32'd5, 64'd15, 33, 0, 0, 64'd15, 2'b00, 33};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 33, 0, 5,
                    64'hFFFFFFFE00000001, 2'b00, 33};
        vecs[2] = '{32'd7, 32'd9, 64'd63, 0, 0, 0, 64'd0, 2'b01, 40};
        vecs[3] = '{32'd2, 32'd4, 64'd8, 10, 10, 0, 64'd0, 2'b10, 10};
        vecs[4] = '{32'd6, 32'd7, 64'd42, 40, 0, 1, 64'd42, 2'b00, 40};
        vecs[5] = '{32'd11, 32'd13, 64'd143, 0, 5, 0, 64'd0, 2'b10, 5};
        vecs[6] = '{32'd100, 32'd200, 64'd20000, 1, 0, 2, 64'd20000, 2'b00, 1};
        vecs[7] = '{32'h1234, 32'h10, 64'h12340, 8, 1, 0, 64'd0, 2'b10, 1};

        // Reset state is visible immediately, before any clock edge.
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // op_done in IDLE must not change anything.
        op_done    = 1'b1;
        mul_result = 64'h5555_AAAA_5555_AAAA;
        @(negedge clk);
        op_done = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle_done");
        $display("txn idle: op_done pulse in IDLE, busy=%0b req_ready=%0b", busy, req_ready);

        for (int i = 0; i < 8; i++) begin
            run_op(i, vecs[i]);
        end

        // Reset during WAIT cycle 10: all outputs clear at once, and no op_clear follows.
        req_valid = 1'b1;
        req_a     = 32'd21;
        req_b     = 32'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_op_start", op_start, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
        end
        chk("rst_mid_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        chk("rst_mid_no_clear1", op_clear, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_clear2", op_clear, 0);
        chk("rst_mid_idle", req_ready, 1);
        $display("txn reset: reset in WAIT cycle 10, op_clear=%0b req_ready=%0b", op_clear, req_ready);

        run_op(8, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
